mux_sel_rr_arbiter: RTL



---
 rtl/mux_sel_rr_arbiter_if.sv | 11 +
 rtl/mux_sel_rr_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mux_sel_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the mux-select arbiter.
// master: requester side (drives req); slave: arbiter side (drives grant/select).
interface mux_sel_rr_arbiter_if;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        gnt_valid;

    modport master (output req, input gnt, input sel, input gnt_valid);
    modport slave  (input req, output gnt, output sel, output gnt_valid);
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 16:1 bit mux.
// One owner at a time; a tenure ends on release or after MAX_HOLD cycles
// while others wait (MAX_HOLD = 0 disables the limit). Handoffs have no
// idle bubble, and sel holds its last value while idle.
module mux_sel_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_sel_rr_arbiter_if.slave  bus
);

    localparam int unsigned    HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [15:0]    gnt_q, gnt_d;
    logic [3:0]     sel_q, sel_d;
    logic           valid_q, valid_d;

    logic [3:0]     next_idx;
    logic [15:0]    others;
    logic [3:0]     win;

    // First set bit of vec scanning start, start+1, ... wrapping 15 -> 0.
    function automatic logic [3:0] search(input logic [15:0] vec, input logic [3:0] start);
        logic [3:0] idx;
        logic       found;
        search = start;
        found  = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            idx = start + 4'(i);
            if (!found && vec[idx]) begin
                search = idx;
                found  = 1'b1;
            end
        end
    endfunction

    assign next_idx = sel_q + 4'd1;
    assign others   = bus.req & ~(16'h0001 << sel_q);

    // Next-state, pointer, hold counter and registered-output values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        win     = '0;

        unique case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (|bus.req) begin
                    win     = search(bus.req, ptr_q);
                    gnt_d   = 16'h0001 << win;
                    sel_d   = win;
                    valid_d = 1'b1;
                    hold_d  = HW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    // Release: rotate past the owner, hand off directly if anyone waits.
                    ptr_d = next_idx;
                    if (|bus.req) begin
                        win    = search(bus.req, next_idx);
                        gnt_d  = 16'h0001 << win;
                        sel_d  = win;
                        hold_d = HW'(1);
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD != 0 && hold_q == HOLD_MAX) begin
                    // Timeout: pass the grant on only if another requester waits.
                    hold_d = HW'(1);
                    if (|others) begin
                        ptr_d = next_idx;
                        win   = search(others, next_idx);
                        gnt_d = 16'h0001 << win;
                        sel_d = win;
                    end
                end else if (MAX_HOLD != 0 && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.gnt_valid = valid_q;

endmodule
